// File: rtl/adder64_reg_if.sv
// ============================================================================
// Module   : adder64_reg_if
// Brief    : Operand/result bundle for the registered 64-bit CLA adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface adder64_reg_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output a, b, cin,
    input  s, cout, ovf
  );

  modport slave (
    input  a, b, cin,
    output s, cout, ovf
  );
endinterface

`default_nettype wire

// File: rtl/adder64_reg.sv
// ============================================================================
// Module   : adder64_reg
// Brief    : 64-bit hierarchical carry-lookahead adder with registered
//            sum, carry-out and signed-overflow (one-cycle latency).
// Revision : 1.0
// ============================================================================
`default_nettype none

module adder64_reg #(
  parameter int WIDTH = 64
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  adder64_reg_if.slave     bus
);

  localparam int c_GROUPS = WIDTH / 4;
  localparam int c_BLOCKS = WIDTH / 16;

  // Group generate/propagate over four (g,p) pairs: {G, P}.
  function automatic logic [1:0] f_gp(input logic [3:0] g, input logic [3:0] p);
    logic [1:0] r;
    r[1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    r[0] = &p;
    return r;
  endfunction

  // Flattened lookahead carries c1..c3 from c0.
  function automatic logic [2:0] f_carry3(input logic [2:0] g, input logic [2:0] p,
                                          input logic c0);
    logic [2:0] r;
    r[0] = g[0] | (p[0] & c0);
    r[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    r[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return r;
  endfunction

  logic [WIDTH-1:0]    w_g;
  logic [WIDTH-1:0]    w_p;
  logic [WIDTH-1:0]    w_c;
  logic [c_GROUPS-1:0] w_gg;
  logic [c_GROUPS-1:0] w_gp;
  logic [c_GROUPS-1:0] w_cg_in;
  logic [c_BLOCKS-1:0] w_bg;
  logic [c_BLOCKS-1:0] w_bp;
  logic [c_BLOCKS:0]   w_cblk;
  logic [1:0]          w_gp_top;
  logic [WIDTH-1:0]    w_sum;
  logic                w_cout;
  logic                w_ovf;

  logic [WIDTH-1:0]    r_s;
  logic                r_cout;
  logic                r_ovf;

  assign w_g = bus.a & bus.b;
  assign w_p = bus.a ^ bus.b;

  generate
    for (genvar j = 0; j < c_GROUPS; j++) begin : g_grp_gp
      assign {w_gg[j], w_gp[j]} = f_gp(w_g[4*j +: 4], w_p[4*j +: 4]);
    end

    for (genvar k = 0; k < c_BLOCKS; k++) begin : g_blk_gp
      assign {w_bg[k], w_bp[k]} = f_gp(w_gg[4*k +: 4], w_gp[4*k +: 4]);
    end
  endgenerate

  // Top level: carries into blocks 1..3 and the final carry-out, all from cin.
  assign w_gp_top     = f_gp(w_bg, w_bp);
  assign w_cblk[0]    = bus.cin;
  assign w_cblk[3:1]  = f_carry3(w_bg[2:0], w_bp[2:0], bus.cin);
  assign w_cblk[4]    = w_gp_top[1] | (w_gp_top[0] & bus.cin);

  generate
    for (genvar k = 0; k < c_BLOCKS; k++) begin : g_blk_carry
      logic [2:0] w_cl;
      assign w_cl                 = f_carry3(w_gg[4*k +: 3], w_gp[4*k +: 3], w_cblk[k]);
      assign w_cg_in[4*k +: 4]    = {w_cl, w_cblk[k]};
    end

    for (genvar j = 0; j < c_GROUPS; j++) begin : g_grp_carry
      logic [2:0] w_cl;
      assign w_cl              = f_carry3(w_g[4*j +: 3], w_p[4*j +: 3], w_cg_in[j]);
      assign w_c[4*j +: 4]     = {w_cl, w_cg_in[j]};
    end
  endgenerate

  assign w_sum  = w_p ^ w_c;
  assign w_cout = w_cblk[c_BLOCKS];
  assign w_ovf  = w_cout ^ w_c[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s    <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_s    <= w_sum;
      r_cout <= w_cout;
      r_ovf  <= w_ovf;
    end
  end

  assign bus.s    = r_s;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_adder64_reg.sv
// ============================================================================
// Module   : tb_adder64_reg
// Brief    : Scoreboard bench for adder64_reg against a 65-bit golden sum.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_adder64_reg;

  typedef struct packed {
    logic [63:0] s;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t q_exp[$];

  adder64_reg_if #(.WIDTH(64)) u_if ();

  adder64_reg #(.WIDTH(64)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic cin);
    logic [64:0] t;
    exp_t        e;
    t      = {1'b0, a} + {1'b0, b} + {64'd0, cin};
    e.s    = t[63:0];
    e.cout = t[64];
    e.ovf  = (a[63] == b[63]) && (t[63] != a[63]);
    return e;
  endfunction

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic cin);
    @(negedge clk);
    u_if.a   = a;
    u_if.b   = b;
    u_if.cin = cin;
    q_exp.push_back(model(a, b, cin));
  endtask

  // Each pushed operation is sampled at the next rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && q_exp.size() > 0) begin
      e = q_exp.pop_front();
      chk("sum",  u_if.s, e.s);
      chk("cout", {63'd0, u_if.cout}, {63'd0, e.cout});
      chk("ovf",  {63'd0, u_if.ovf},  {63'd0, e.ovf});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    u_if.a   = 64'd5;
    u_if.b   = 64'd7;
    u_if.cin = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_s",    u_if.s, 64'd0);
    chk("rst_cout", {63'd0, u_if.cout}, 64'd0);
    chk("rst_ovf",  {63'd0, u_if.ovf},  64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    q_exp.push_back(model(64'd5, 64'd7, 1'b0));

    send(64'd2, 64'd3, 1'b0);
    send(64'd100, 64'd200, 1'b0);
    send(64'h40000000, 64'h40000000, 1'b0);
    send(64'h7FFFFFFFFFFFFFFE, 64'd1, 1'b0);
    send(64'h7FFFFFFFFFFFFFFF, 64'd1, 1'b0);
    send(64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1);
    send(64'h8000000000000000, 64'h8000000000000000, 1'b0);
    send(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1);
    send(64'h000000000000FFFF, 64'd0, 1'b1);
    send(64'h0000FFFFFFFFFFFF, 64'd1, 1'b0);

    // Back-to-back random traffic, biased toward long carry chains.
    for (int i = 0; i < 1200; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: rb = ~ra;
        1: ra = 64'hFFFFFFFFFFFFFFFF;
        2: begin ra[63] = 1'b0; rb[63] = 1'b0; end
        3: begin ra[63] = 1'b1; rb[63] = 1'b1; end
        default: ;
      endcase
      send(ra, rb, 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 10 && q_exp.size() > 0; i++) @(posedge clk);
    #2;
    chk("drain", 64'(q_exp.size()), 64'd0);

    // Asynchronous reset mid-operation: in-flight result dropped, outputs clear without an edge.
    send(64'd1, 64'd1, 1'b0);
    send(64'd3, 64'd4, 1'b0);
    #2;
    rst_n = 1'b0;
    q_exp.delete();
    #1;
    chk("async_s",    u_if.s, 64'd0);
    chk("async_cout", {63'd0, u_if.cout}, 64'd0);
    @(posedge clk);
    #1;
    chk("hold_s", u_if.s, 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    send(64'hFFFFFFFF, 64'd1, 1'b0);
    for (int i = 0; i < 10 && q_exp.size() > 0; i++) @(posedge clk);
    #2;
    chk("drain2", 64'(q_exp.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
